// File: rtl/pipelined_tree_multiplier.sv
// Pipelined sign-magnitude multiplier: partial products registered at stage 0,
// then reduced by a registered binary adder tree with a global stall enable.
`timescale 1ns/1ps
module pipelined_tree_multiplier #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     in_a,
  input  logic [SIZE-1:0]     in_b,
  input  logic                in_signed,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*SIZE-1:0]   out_prod,
  output logic                out_signed,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int unsigned L  = (SIZE > 1) ? $clog2(SIZE) : 0;
  localparam int unsigned PW = 2 * SIZE;

  function automatic int unsigned terms_at(int unsigned lvl);
    int unsigned n;
    n = SIZE;
    for (int unsigned k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  logic            w_en;
  logic [SIZE-1:0] w_a_mag;
  logic [SIZE-1:0] w_b_mag;
  logic [PW-1:0]   w_pp [SIZE];
  logic [PW-1:0]   w_fin;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Magnitudes are SIZE-bit unsigned, so -2^(SIZE-1) negates to 2^(SIZE-1).
  always_comb begin
    w_a_mag = (in_signed && in_a[SIZE-1]) ? (~in_a + SIZE'(1)) : in_a;
    w_b_mag = (in_signed && in_b[SIZE-1]) ? (~in_b + SIZE'(1)) : in_b;
    for (int unsigned i = 0; i < SIZE; i++) begin
      w_pp[i] = w_b_mag[i] ? ({{SIZE{1'b0}}, w_a_mag} << i) : '0;
    end
  end

  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int unsigned N = terms_at(k);
    logic [PW-1:0]    r_t [N];
    logic             r_v;
    logic             r_neg;
    logic             r_sgn;
    logic [TAG_W-1:0] r_tag;

    if (k == 0) begin : g_in
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v   <= 1'b0;
          r_neg <= 1'b0;
          r_sgn <= 1'b0;
          r_tag <= '0;
          for (int unsigned i = 0; i < N; i++) r_t[i] <= '0;
        end else if (w_en) begin
          r_v   <= in_valid;
          r_neg <= in_signed & (in_a[SIZE-1] ^ in_b[SIZE-1]);
          r_sgn <= in_signed;
          r_tag <= in_tag;
          for (int unsigned i = 0; i < N; i++) r_t[i] <= w_pp[i];
        end
      end
    end else begin : g_add
      localparam int unsigned NP = terms_at(k - 1);
      logic [PW-1:0] w_sum [N];

      // Odd term count: the last term passes through unchanged.
      for (genvar j = 0; j < N; j++) begin : g_pair
        if (2 * j + 1 < NP) begin : g_sum2
          assign w_sum[j] = g_lvl[k-1].r_t[2*j] + g_lvl[k-1].r_t[2*j+1];
        end else begin : g_pass
          assign w_sum[j] = g_lvl[k-1].r_t[2*j];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v   <= 1'b0;
          r_neg <= 1'b0;
          r_sgn <= 1'b0;
          r_tag <= '0;
          for (int unsigned i = 0; i < N; i++) r_t[i] <= '0;
        end else if (w_en) begin
          r_v   <= g_lvl[k-1].r_v;
          r_neg <= g_lvl[k-1].r_neg;
          r_sgn <= g_lvl[k-1].r_sgn;
          r_tag <= g_lvl[k-1].r_tag;
          for (int unsigned i = 0; i < N; i++) r_t[i] <= w_sum[i];
        end
      end
    end
  end

  assign w_fin      = g_lvl[L].r_t[0];
  assign out_prod   = g_lvl[L].r_neg ? (~w_fin + PW'(1)) : w_fin;
  assign out_valid  = g_lvl[L].r_v;
  assign out_signed = g_lvl[L].r_sgn;
  assign out_tag    = g_lvl[L].r_tag;

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Scoreboard bench: directed and random traffic on a SIZE=8 instance plus a
// random sweep over SIZE in {1,2,3,5,8}, all against an integer reference model.
`timescale 1ns/1ps
module tb_pipelined_tree_multiplier;

  typedef struct {
    logic [63:0] prod;
    logic        sgn;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Operands interpreted as integers, multiplied, truncated to 2*sz bits.
  function automatic logic [63:0] ref_mul(int unsigned sz, logic [63:0] a, logic [63:0] b, logic s);
    longint va, vb, p;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[sz-1]) va = va - (longint'(1) << sz);
    if (s && b[sz-1]) vb = vb - (longint'(1) << sz);
    p = va * vb;
    return 64'(p) & ((64'd1 << (2 * sz)) - 64'd1);
  endfunction

  function automatic int unsigned sw_size(int unsigned g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 5;
      default: return 8;
    endcase
  endfunction

  // ---------------- main SIZE=8 instance ----------------
  logic       rst_n, sw_rst_n;
  logic       m_iv, m_ir, m_sg, m_ov, m_or, m_os;
  logic [7:0] m_a, m_b;
  logic [3:0] m_it, m_ot;
  logic [15:0] m_op;
  exp_t       mq[$];
  bit         m_lat;

  pipelined_tree_multiplier #(.SIZE(8), .TAG_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir),
    .in_a(m_a), .in_b(m_b), .in_signed(m_sg), .in_tag(m_it),
    .out_valid(m_ov), .out_ready(m_or), .out_prod(m_op),
    .out_signed(m_os), .out_tag(m_ot)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m_ov && m_or) begin
        if (mq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m_unexpected: got result tag=%0h prod=0x%0h expected none", m_ot, m_op);
        end else begin
          e = mq.pop_front();
          check("m_prod", m_op, e.prod);
          check("m_tag", m_ot, e.tag);
          check("m_signed", m_os, e.sgn);
          if (e.lat) check("m_latency", 64'(cyc - e.cyc), 4);
        end
      end
      if (m_iv && m_ir)
        mq.push_back('{ref_mul(8, m_a, m_b, m_sg), m_sg, m_it, cyc, m_lat});
    end
  end

  task automatic issue(logic [7:0] a, logic [7:0] b, logic s, logic [3:0] t);
    m_a = a; m_b = b; m_sg = s; m_it = t; m_iv = 1'b1;
    @(posedge clk); #1;
    m_iv = 1'b0;
  endtask

  task automatic m_drain(string name, int n);
    for (int k = 0; k < n && mq.size() != 0; k++) @(posedge clk);
    #1;
    check(name, mq.size(), 0);
  endtask

  // ---------------- parameter sweep ----------------
  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int unsigned SZ  = sw_size(g);
    localparam int unsigned LAT = ((SZ > 1) ? $clog2(SZ) : 0) + 1;
    logic          iv, ir, sg, ov, orr, os, done;
    logic [SZ-1:0] a, b;
    logic [3:0]    it, ot;
    logic [2*SZ-1:0] op;
    exp_t          q[$];
    bit            lat;

    pipelined_tree_multiplier #(.SIZE(SZ), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir),
      .in_a(a), .in_b(b), .in_signed(sg), .in_tag(it),
      .out_valid(ov), .out_ready(orr), .out_prod(op),
      .out_signed(os), .out_tag(ot)
    );

    always @(negedge clk) begin
      exp_t e;
      if (sw_rst_n) begin
        if (ov && orr) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sw%0d_unexpected: got tag=%0h expected none", SZ, ot);
          end else begin
            e = q.pop_front();
            check($sformatf("sw%0d_prod", SZ), op, e.prod);
            check($sformatf("sw%0d_tag", SZ), ot, e.tag);
            check($sformatf("sw%0d_signed", SZ), os, e.sgn);
            if (e.lat) check($sformatf("sw%0d_latency", SZ), 64'(cyc - e.cyc), 64'(LAT));
          end
        end
        if (iv && ir)
          q.push_back('{ref_mul(SZ, 64'(a), 64'(b), sg), sg, it, cyc, lat});
      end
    end

    initial begin
      iv = 1'b0; a = '0; b = '0; sg = 1'b0; it = '0; orr = 1'b1; lat = 1'b0; done = 1'b0;
      wait (sw_rst_n);
      @(posedge clk); #1;
      lat = 1'b1;
      for (int n = 0; n < 3; n++) begin
        a = SZ'($urandom); b = SZ'($urandom); sg = 1'($urandom); it = 4'(n + 9); iv = 1'b1;
        @(posedge clk); #1;
      end
      iv = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      lat = 1'b0;
      repeat (400) begin
        iv  = 1'($urandom);
        a   = SZ'($urandom);
        b   = SZ'($urandom);
        sg  = 1'($urandom);
        it  = 4'($urandom);
        orr = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      iv = 1'b0; orr = 1'b1;
      for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
      #1;
      check($sformatf("sw%0d_drain", SZ), q.size(), 0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit          found;
    logic [15:0] hold_p;
    logic [3:0]  hold_t;
    rst_n = 1'b0; sw_rst_n = 1'b0;
    m_iv = 1'b0; m_a = '0; m_b = '0; m_sg = 1'b0; m_it = '0; m_or = 1'b0; m_lat = 1'b0;
    #12;
    check("rst_out_valid", m_ov, 0);
    check("rst_out_prod", m_op, 0);
    check("rst_out_signed", m_os, 0);
    check("rst_out_tag", m_ot, 0);
    check("rst_in_ready", m_ir, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; sw_rst_n = 1'b1; m_or = 1'b1;
    @(posedge clk); #1;

    // single unsigned full-range op, valid held exactly one cycle
    m_lat = 1'b1;
    issue(8'hFF, 8'hFF, 1'b0, 4'd3);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_ov) begin found = 1'b1; break; end
    end
    check("t1_seen", found, 1);
    @(negedge clk);
    check("t1_one_cycle", m_ov, 0);
    @(posedge clk); #1;

    // signed corner cases
    issue(8'h80, 8'h80, 1'b1, 4'd1);
    issue(8'h80, 8'h7F, 1'b1, 4'd2);
    issue(8'h00, 8'hFB, 1'b1, 4'd4);
    issue(8'h80, 8'h80, 1'b0, 4'd5);
    issue(8'hFF, 8'h01, 1'b1, 4'd6);
    m_drain("sgn_drain", 12);

    // streaming back-to-back
    for (int i = 0; i < 6; i++) issue(8'(i + 1), 8'd10, 1'b0, 4'(i));
    m_drain("stream_drain", 12);

    // backpressure with a full pipeline
    m_lat = 1'b0;
    for (int i = 0; i < 4; i++) issue(8'($urandom), 8'($urandom), 1'($urandom), 4'(i + 8));
    m_or = 1'b0;
    hold_p = m_op;
    hold_t = m_ot;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", m_ir, 0);
      check("bp_out_valid", m_ov, 1);
      check("bp_prod_stable", m_op, hold_p);
      check("bp_tag_stable", m_ot, hold_t);
    end
    @(posedge clk); #1;
    m_or = 1'b1;
    m_drain("bp_drain", 12);

    // asynchronous reset with work in flight
    for (int i = 0; i < 3; i++) issue(8'(i + 3), 8'd7, 1'b0, 4'(i + 12));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", m_ov, 0);
    check("arst_in_ready", m_ir, 1);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("arst_no_stale", m_ov, 0);
    end
    @(posedge clk); #1;
    m_lat = 1'b1;
    issue(8'd7, 8'd9, 1'b0, 4'd5);
    m_drain("arst_new_op", 12);

    // random traffic with random backpressure
    m_lat = 1'b0;
    repeat (300) begin
      m_iv = 1'($urandom);
      m_a  = 8'($urandom);
      m_b  = 8'($urandom);
      m_sg = 1'($urandom);
      m_it = 4'($urandom);
      m_or = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    m_iv = 1'b0; m_or = 1'b1;
    m_drain("rand_drain", 40);

    for (int n = 0; n < 5000; n++) begin
      if (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done) break;
      @(posedge clk);
    end
    check("sweep_done", {g_sw[0].done, g_sw[1].done, g_sw[2].done, g_sw[3].done, g_sw[4].done}, 5'b11111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
